// File: rtl/seed_stream_ctrl.sv
// -----------------------------------------------------------------------------
// seed_stream_ctrl
//
// Purpose:
//   Sequencer and buffer around a serialized SEED round engine. Plaintext and
//   key arrive together as DATA_W-bit valid/ready beats (MSB-first). The
//   controller walks the engine through ROUNDS rounds of BEATS+1 cycles each
//   (BEATS data beats plus one pad/mix cycle). It captures the final-round
//   output into one of two egress buffers, then streams the ciphertext out
//   under backpressure, so block N+1 can load and run while block N drains.
//
// Optional feature:
//   SEED_DECRYPT_EN - adds the 'mode' input and the 'eng_dec' output. In
//   decrypt mode the round index counts ROUNDS..1. Capture then happens in
//   the round where eng_round == 1.
//
// Parameters:
//   DATA_W  beat width (8, 16 or 32); BEATS = 128/DATA_W is derived.
//   ROUNDS  number of rounds (1..31).
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          ingress handshake
//   in_data/in_key             plaintext and key beat
//   out_valid/out_ready        egress handshake
//   out_data/out_last          ciphertext beat and end-of-block marker
//   busy                       FSM not in IDLE
//   eng_en                     engine enable
//   eng_beat/eng_round         engine beat (0..BEATS) and round counters
//   eng_din                    ingress beat fed to the engine in the first round
//   eng_key                    key beat fed to the engine while loading
//   eng_dout                   engine LR output beat
//   mode/eng_dec               (SEED_DECRYPT_EN only) decrypt select and its latch
// -----------------------------------------------------------------------------
module seed_stream_ctrl #(
    parameter int DATA_W = 8,
    parameter int ROUNDS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
`ifdef SEED_DECRYPT_EN
    input  logic              mode,
    output logic              eng_dec,
`endif
    output logic              eng_en,
    output logic [4:0]        eng_beat,
    output logic [4:0]        eng_round,
    output logic [DATA_W-1:0] eng_din,
    output logic [DATA_W-1:0] eng_key,
    input  logic [DATA_W-1:0] eng_dout
);

    localparam int            BEATS    = 128 / DATA_W;
    localparam int            IW       = $clog2(BEATS);
    localparam logic [4:0]    BEATS_B  = 5'(BEATS);
    localparam logic [4:0]    LOAD_END = 5'(BEATS - 1);
    localparam logic [4:0]    ROUNDS_B = 5'(ROUNDS);
    localparam logic [IW-1:0] IDX_LAST = IW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_CAPT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        beat_q, beat_d;
    logic [4:0]        round_q, round_d;
    logic              run_en_q, run_en_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              dec_q, dec_d;
    logic [DATA_W-1:0] ing_q [BEATS];
    logic [DATA_W-1:0] ing_d [BEATS];
    logic [DATA_W-1:0] ebuf_q [2][BEATS];
    logic [DATA_W-1:0] ebuf_d [2][BEATS];
    logic [1:0]        full_q, full_d;
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [IW-1:0]     rd_idx_q, rd_idx_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              accept_s;
    logic              mode_s;

    // First round of a block: round 1 when encrypting, ROUNDS when decrypting.
    function automatic logic [4:0] first_round(input logic dec);
        return dec ? ROUNDS_B : 5'd1;
    endfunction

    // Capture round: ROUNDS when encrypting, round 1 when decrypting.
    function automatic logic [4:0] last_round(input logic dec);
        return dec ? 5'd1 : ROUNDS_B;
    endfunction

`ifdef SEED_DECRYPT_EN
    assign mode_s  = mode;
    assign eng_dec = dec_q;
`else
    assign mode_s  = 1'b0;
`endif

    assign accept_s = in_valid & in_ready_q;

    // Next-state logic: FSM, counters, ingress shifter, egress fill/drain.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        round_d  = round_q;
        dec_d    = dec_q;
        ing_d    = ing_q;
        ebuf_d   = ebuf_q;
        full_d   = full_q;
        head_d   = head_q;
        tail_d   = tail_q;
        rd_idx_d = rd_idx_q;

        // Drain first: a freed buffer is visible to the stall check below.
        if (out_valid_q && out_ready) begin
            if (rd_idx_q == IDX_LAST) begin
                full_d[head_q] = 1'b0;
                head_d         = ~head_q;
                rd_idx_d       = '0;
            end else begin
                rd_idx_d = rd_idx_q + IW'(1);
            end
        end else begin
            rd_idx_d = rd_idx_q;
        end

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    ing_d[0] = in_data;
                    for (int i = 1; i < BEATS; i++) ing_d[i] = ing_q[i-1];
                    dec_d   = mode_s;
                    beat_d  = 5'd1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (accept_s) begin
                    ing_d[0] = in_data;
                    for (int i = 1; i < BEATS; i++) ing_d[i] = ing_q[i-1];
                    if (beat_q == LOAD_END) begin
                        beat_d  = 5'd0;
                        round_d = first_round(dec_q);
                        state_d = S_RUN;
                    end else begin
                        beat_d = beat_q + 5'd1;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RUN: begin
                if (run_en_q) begin
                    // First round: pop the oldest ingress beat toward eng_din.
                    if (round_q == first_round(dec_q) && beat_q < BEATS_B) begin
                        ing_d[0] = '0;
                        for (int i = 1; i < BEATS; i++) ing_d[i] = ing_q[i-1];
                    end else begin
                        ing_d[0] = ing_q[0];
                    end
                    // Capture round: only ever writes the tail, which is not full.
                    if (round_q == last_round(dec_q) && beat_q < BEATS_B) begin
                        ebuf_d[tail_q][beat_q[IW-1:0]] = eng_dout;
                    end else begin
                        ebuf_d[tail_q][0] = ebuf_q[tail_q][0];
                    end
                    if (beat_q == BEATS_B) begin
                        beat_d = 5'd0;
                        if (round_q == last_round(dec_q)) begin
                            round_d = 5'd0;
                            state_d = S_CAPT;
                        end else if (dec_q) begin
                            round_d = round_q - 5'd1;
                        end else begin
                            round_d = round_q + 5'd1;
                        end
                    end else begin
                        beat_d = beat_q + 5'd1;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_CAPT: begin
                full_d[tail_q] = 1'b1;
                tail_d         = ~tail_q;
                if (accept_s) begin
                    ing_d[0] = in_data;
                    for (int i = 1; i < BEATS; i++) ing_d[i] = ing_q[i-1];
                    dec_d   = mode_s;
                    beat_d  = 5'd1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Hold the engine at the start of the capture round while no buffer is free.
        run_en_d   = (state_d == S_RUN) &&
                     !(round_d == last_round(dec_d) && beat_d == 5'd0 && full_d[tail_d]);
        in_ready_d = (state_d != S_RUN);
        busy_d     = (state_d != S_IDLE);

        out_valid_d = full_d[head_d];
        out_last_d  = out_valid_d && (rd_idx_d == IDX_LAST);
        if (out_valid_d) begin
            out_data_d = ebuf_q[head_d][rd_idx_d];
        end else begin
            out_data_d = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            beat_q      <= 5'd0;
            round_q     <= 5'd0;
            run_en_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            dec_q       <= 1'b0;
            full_q      <= 2'b00;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < BEATS; i++) begin
                ing_q[i]     <= '0;
                ebuf_q[0][i] <= '0;
                ebuf_q[1][i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            round_q     <= round_d;
            run_en_q    <= run_en_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            dec_q       <= dec_d;
            full_q      <= full_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            rd_idx_q    <= rd_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            ing_q       <= ing_d;
            ebuf_q      <= ebuf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign eng_beat  = beat_q;
    assign eng_round = round_q;
    // Key beats and their enable pass straight through on the accepting cycle.
    assign eng_en    = run_en_q | accept_s;
    assign eng_key   = accept_s ? in_key : '0;
    assign eng_din   = (state_q == S_RUN && round_q == first_round(dec_q) && beat_q < BEATS_B)
                       ? ing_q[BEATS-1] : '0;

endmodule

// File: tb/tb_seed_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seed_stream_ctrl
//
// Scoreboard bench for seed_stream_ctrl (DATA_W=8, ROUNDS=16). A behavioural
// engine stub stands in for the SEED datapath. It records the key beats seen
// during load and the plaintext beats seen in the first round. In the capture
// round it returns ct[i] ^ pt[i] ^ i ^ key[i], where ct is the reference
// ciphertext for key 0 and plaintext 00..0F. The driver pushes the expected
// beats and the monitor pops them on every out_valid & out_ready.
// -----------------------------------------------------------------------------
module tb_seed_stream_ctrl;

    localparam logic [127:0] CT_VEC = 128'h5EBAC6E0054E166819AFF1CC6D346CDB;
    localparam logic [127:0] PT_INC = 128'h000102030405060708090A0B0C0D0E0F;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [7:0] in_key = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       eng_en;
    logic [4:0] eng_beat;
    logic [4:0] eng_round;
    logic [7:0] eng_din;
    logic [7:0] eng_key;
    logic [7:0] eng_dout;
    logic       dec_s;
`ifdef SEED_DECRYPT_EN
    logic       mode = 1'b0;
    logic       eng_dec;
    assign dec_s = eng_dec;
`else
    assign dec_s = 1'b0;
`endif

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t_first = 0;
    int         t_last = 0;
    bit         lat_pending = 1'b0;
    bit         chk_ready = 1'b0;
    bit         chk_load = 1'b0;
    int         en_load = 0;
    logic [8:0] exp_q [$];
    logic [8:0] mon_e;
    logic [7:0] ctab [16];
    logic [7:0] pt_seen [16];
    logic [7:0] key_seen [16];
    logic [4:0] first_r, last_r;
    logic       prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [7:0] prev_d = 8'h00;

    seed_stream_ctrl #(.DATA_W(8), .ROUNDS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
`ifdef SEED_DECRYPT_EN
        .mode      (mode),
        .eng_dec   (eng_dec),
`endif
        .eng_en    (eng_en),
        .eng_beat  (eng_beat),
        .eng_round (eng_round),
        .eng_din   (eng_din),
        .eng_key   (eng_key),
        .eng_dout  (eng_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine stub: remember key and first-round data, answer in the capture round.
    always_comb begin
        first_r = dec_s ? 5'd16 : 5'd1;
        last_r  = dec_s ? 5'd1 : 5'd16;
    end

    always @(posedge clk) begin
        if (eng_en && eng_round == 5'd0 && eng_beat < 5'd16) key_seen[eng_beat[3:0]] <= eng_key;
        if (eng_en && eng_round == first_r && eng_beat < 5'd16) pt_seen[eng_beat[3:0]] <= eng_din;
    end

    always_comb begin
        eng_dout = 8'hEE ^ {3'b000, eng_round};
        if (eng_round == last_r && eng_beat < 5'd16) begin
            eng_dout = ctab[eng_beat[3:0]] ^ pt_seen[eng_beat[3:0]] ^
                       {4'h0, eng_beat[3:0]} ^ key_seen[eng_beat[3:0]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, latency, stability under backpressure, load enables.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && lat_pending) begin
                chk("latency", 64'(cyc + 1 - t_last), 64'd274);
                lat_pending = 1'b0;
            end
            if (out_valid && prev_v && !prev_r) begin
                chk("hold_stable", 64'({out_last, out_data}), 64'({prev_l, prev_d}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'({out_last, out_data}), 64'h1FF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_beat", 64'({out_last, out_data}), 64'(mon_e));
                end
            end
            if (chk_ready && !in_ready) chk("ready_low_only_run", 64'(eng_round != 5'd0), 64'd1);
            if (chk_load && eng_round == 5'd0) begin
                chk("load_en", 64'(eng_en), 64'(in_valid && in_ready));
                if (eng_en) en_load++;
            end
        end
        prev_v = out_valid;
        prev_r = out_ready;
        prev_d = out_data;
        prev_l = out_last;
    end

    // Drive one 16-beat block; expectations are pushed as beats are accepted.
    task automatic send_block(input logic [127:0] pt, input logic [127:0] key,
                              input bit bubbles, input bit push);
        logic [7:0] pb, kb;
        for (int i = 0; i < 16; i++) begin
            int w = 0;
            pb = pt[127 - 8*i -: 8];
            kb = key[127 - 8*i -: 8];
            in_valid = 1'b1;
            in_data  = pb;
            in_key   = kb;
            @(negedge clk);
            while (!in_ready && w < 2000) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                $display("FAIL in_accept_timeout: got in_ready=0 after %0d cycles, expected 1", w);
                errors++;
                checks++;
            end
            if (i == 0) t_first = cyc + 1;
            t_last = cyc + 1;
            if (push) exp_q.push_back({(i == 15), ctab[i] ^ pb ^ 8'(i) ^ kb});
            @(posedge clk);
            #1;
            if (bubbles) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || busy || out_valid) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n < limit), 64'd1);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk(name, 64'({in_ready, out_valid, out_last, busy, eng_en, eng_beat, eng_round,
                       eng_din, eng_key, out_data}), 64'd0);
    endtask

    initial begin
        logic [127:0] ct_v;
        int           n;
        int           tl;
        ct_v = CT_VEC;
        for (int i = 0; i < 16; i++) ctab[i] = ct_v[127 - 8*i -: 8];

        // Reset state.
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset_state");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single block with reference vector and nominal latency.
        out_ready = 1'b1;
        send_block(PT_INC, 128'h0, 1'b0, 1'b1);
        in_valid    = 1'b0;
        lat_pending = 1'b1;
        wait_drain("single_drain", 1000);
        @(posedge clk);
        #1;

        // Back-to-back blocks with in_valid held high.
        chk_ready = 1'b1;
        send_block(PT_INC, 128'h0, 1'b0, 1'b1);
        tl = t_last;
        send_block(PT_INC, 128'h0, 1'b0, 1'b1);
        chk("b2b_gap", 64'(t_first - tl), 64'd273);
        send_block(PT_INC, 128'h0, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_drain("b2b_drain", 2000);
        chk_ready = 1'b0;
        @(posedge clk);
        #1;

        // Backpressure: two blocks fill the buffers, the third stalls at round 16.
        out_ready = 1'b0;
        send_block(PT_INC, 128'h0, 1'b0, 1'b1);
        send_block(128'hFFEEDDCCBBAA99887766554433221100,
                   128'h0123456789ABCDEF0123456789ABCDEF, 1'b0, 1'b1);
        send_block(128'h13579BDF02468ACE13579BDF02468ACE, 128'h0, 1'b0, 1'b1);
        in_valid = 1'b0;
        n = 0;
        while (!(eng_round == 5'd16 && eng_beat == 5'd0 && !eng_en) && n < 600) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        chk("stall_en", 64'(eng_en), 64'd0);
        chk("stall_round", 64'(eng_round), 64'd16);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        wait_drain("bp_drain", 3000);
        @(posedge clk);
        #1;

        // Bubbles during load: enable only on accepted beats.
        en_load  = 0;
        chk_load = 1'b1;
        send_block(PT_INC, 128'h0, 1'b1, 1'b1);
        chk_load = 1'b0;
        in_valid = 1'b0;
        chk("bubble_en_count", 64'(en_load), 64'd16);
        wait_drain("bubble_drain", 1000);
        @(posedge clk);
        #1;

        // Reset during round 7 discards the block; a fresh block runs normally.
        send_block(PT_INC, 128'h0, 1'b0, 1'b0);
        in_valid = 1'b0;
        n = 0;
        while (eng_round != 5'd7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_round7", 64'(eng_round), 64'd7);
        reset = 1'b1;
        @(negedge clk);
        chk_zero_outputs("midrun_reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_block(PT_INC, 128'h0, 1'b0, 1'b1);
        in_valid    = 1'b0;
        lat_pending = 1'b1;
        wait_drain("post_reset_drain", 1000);
        @(posedge clk);
        #1;

`ifdef SEED_DECRYPT_EN
        // Decrypt: rounds count down and the reference ciphertext maps back.
        mode = 1'b1;
        send_block(CT_VEC, 128'h0, 1'b0, 1'b1);
        mode     = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("dec_first_round", 64'(eng_round), 64'd16);
        begin
            logic [4:0] prev_round;
            int         viol;
            prev_round = eng_round;
            viol       = 0;
            n          = 0;
            while (eng_round != 5'd0 && n < 400) begin
                @(negedge clk);
                n++;
                if (eng_round != prev_round && eng_round != 5'd0 &&
                    eng_round != prev_round - 5'd1) viol++;
                if (eng_round != 5'd0) prev_round = eng_round;
            end
            chk("dec_round_step", 64'(viol), 64'd0);
            chk("dec_last_round", 64'(prev_round), 64'd1);
        end
        wait_drain("dec_drain", 1000);
`endif

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seed_stream_ctrl.md
Name: seed_stream_ctrl

Overview:
- Parametrised sequencer and buffer around the serialized SEED round engine (round block plus key schedule).
- Accepts plaintext and key as a valid/ready beat stream of DATA_W bits and drives the engine's beat and round counters with an enable.
- Captures the final-round output into a double-buffered egress store and streams the ciphertext out under backpressure, so block N+1 loads and runs while block N drains.

Parameters:
- DATA_W, 8, beat width in bits; must divide 128; legal values 8, 16, 32.
- ROUNDS, 16, number of rounds; legal range 1..31.
- BEATS, 128/DATA_W, beats per block; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  plaintext/key beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_data  in  DATA_W  plaintext beat, MSB-first block order
- in_key  in  DATA_W  key beat, sampled with in_data
- out_valid  out  1  ciphertext beat valid
- out_ready  in  1  sink accepts beat
- out_data  out  DATA_W  ciphertext beat, MSB-first
- out_last  out  1  high on beat BEATS-1 of a block
- busy  out  1  high in any state but IDLE
- eng_en  out  1  engine clock enable
- eng_beat  out  5  beat index 0..BEATS (BEATS = pad/mix cycle)
- eng_round  out  5  round index 1..ROUNDS during RUN, else 0
- eng_din  out  DATA_W  ingress-buffer beat in round 1, else 0
- eng_key  out  DATA_W  key beat during LOAD
- eng_dout  in  DATA_W  engine LR output beat

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_last=0, busy=0, eng_en=0, eng_beat=0, eng_round=0, eng_din=0, eng_key=0, out_data=0. Both egress buffers marked empty; the FSM enters IDLE.
- The reset clears everything mid-operation. A partially loaded or running block is discarded, and the next block restarts at beat 0.
- FSM IDLE -> LOAD -> RUN -> CAPT -> IDLE/LOAD.
- IDLE: in_ready=1. The first accepted beat enters LOAD with beat count 1.
- LOAD:
  - in_ready=1. Each accepted beat shifts into the ingress buffer, and its in_key drives eng_key with eng_en=1 for that cycle.
  - eng_en=0 on cycles with no accepted beat.
  - After BEATS accepted beats, go to RUN at round 1, beat 0.
- RUN:
  - in_ready=0, eng_en=1.
  - eng_beat counts 0..BEATS. On wrap, eng_round increments.
  - Round 1 feeds eng_din from the ingress buffer on beats 0..BEATS-1.
  - Each round lasts BEATS+1 cycles; total RUN is ROUNDS*(BEATS+1) cycles.
  - During round ROUNDS, eng_dout on beats 0..BEATS-1 is written into the free egress buffer.
  - After the final beat, go to CAPT.
- Stall: if neither egress buffer is free at the start of round ROUNDS, eng_en=0 and the counters hold until a buffer frees. Stall cycles add to latency, and no data is lost.
- CAPT:
  - Marks the filled buffer full and queues it for output. This takes one cycle.
  - Go to LOAD if in_valid is high that cycle, else IDLE.
  - in_ready is asserted in CAPT.
- Egress:
  - Buffers drain in fill order.
  - out_valid=1 while the head buffer is full; out_data is the head beat.
  - A beat advances on out_valid & out_ready.
  - The last beat clears the buffer and toggles the head pointer.
  - out_data/out_valid are stable while out_ready=0.
- Latency: last input beat accepted at cycle T -> first out_valid at T+ROUNDS*(BEATS+1)+2, assuming no stall.
- Simultaneous fill and drain of different buffers in one cycle is legal. The buffer being drained is never written.
- Ingress is single-buffered: no new block is accepted during RUN.
- eng_round and eng_beat widths are fixed at 5 bits. Upper bits are zero when parameter ranges are small.

Optional Feature:
- Macro SEED_DECRYPT_EN.
- Defined:
  - Adds input port mode (1 bit, 1=decrypt), sampled on the first accepted beat of a block and held for that block.
  - Adds output eng_dec = latched mode.
  - In decrypt, eng_round counts down ROUNDS..1 so the key schedule emits subkeys in reverse order.
  - Capture occurs during the round where eng_round=1.
- Undefined: no mode/eng_dec ports; encryption only, rounds count up.

Test Plan:
- Single block: DATA_W=8, key all 0x00, plaintext 00 01 .. 0F, out_ready=1 -> out_data 5E BA C6 E0 05 4E 16 68 19 AF F1 CC 6D 34 6C DB. out_last on the 16th beat; first out_valid exactly 16*17+2=274 cycles after the last input beat.
- Back-to-back: three identical blocks with in_valid held high -> three identical ciphertexts. in_ready low only during RUN; no gap between the block-1 and block-2 loads beyond RUN.
- Backpressure: out_ready=0 throughout and three blocks offered -> two blocks captured, third stalls at round 16 with eng_en=0. Raising out_ready releases the stall, and all 48 beats emerge in order with correct values.
- Bubbles: in_valid toggling 1,0,1,0 during LOAD -> eng_en high only on accepted beats; ciphertext matches the single-block vector.
- Reset mid-RUN: assert reset at round 7 for 1 cycle -> all outputs 0 next cycle. A fresh block afterwards yields 5E BA .. DB with nominal latency.
- With SEED_DECRYPT_EN: mode=1, key 0, input 5E BA .. DB -> output 00 01 .. 0F, eng_round sequence 16..1.
